// File: rtl/pwm_capture_spi.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture_spi
// Description : Multi-channel pulse-width / period capture engine with an
//               oversampled SPI-slave (mode 0, MSB first) readout port.
// Revision    : 1.0  initial release
// ============================================================================
module pwm_capture_spi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] comparator,
    input  logic                spi_clk,
    input  logic                spi_mosi,
    input  logic                spi_cs,
    output logic                spi_miso,
    output logic [CHANNELS-1:0] ready
);

    localparam int CHW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NBYTES     = (WIDTH + 7) / 8;
    localparam int c_SYNC_W   = CHANNELS + 3;
    localparam int c_EDGE_W   = CHANNELS + 2;
    localparam int c_LATW     = NBYTES * 8;
    localparam int c_RESP_W   = 8 + c_LATW;
    localparam int c_TOTAL    = (2 + NBYTES) * 8;

    localparam logic [c_SYNC_W-1:0] c_SYNC_RST = {1'b1, {(CHANNELS + 2){1'b0}}};
    localparam logic [c_EDGE_W-1:0] c_EDGE_RST = {1'b1, {(CHANNELS + 1){1'b0}}};
    localparam logic [WIDTH-1:0]    c_CNT_ONE  = {{(WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]    c_MAX      = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]    c_MAX_M1   = {{(WIDTH - 1){1'b1}}, 1'b0};
    localparam logic [6:0]          c_LAST_BIT = 7'(c_TOTAL - 1);
    localparam logic [CHW:0]        c_NCH      = (CHW + 1)'(CHANNELS);
    localparam logic [CHANNELS-1:0] c_ONE_CH   = CHANNELS'(1);

    // ------------------------------------------------------------------
    // Input synchronisers: two flops for metastability, a third for edges.
    // Packed as {cs, mosi, sclk, comparator}; cs idles high.
    // ------------------------------------------------------------------
    logic [c_SYNC_W-1:0] w_async;
    logic [c_SYNC_W-1:0] r_sync1;
    logic [c_SYNC_W-1:0] r_sync2;
    logic [c_EDGE_W-1:0] r_sync3;

    assign w_async = {spi_cs, spi_mosi, spi_clk, comparator};

    // Synchroniser and edge-detect pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= c_SYNC_RST;
            r_sync2 <= c_SYNC_RST;
            r_sync3 <= c_EDGE_RST;
        end else begin
            r_sync1 <= w_async;
            r_sync2 <= r_sync1;
            r_sync3 <= {r_sync2[CHANNELS+2], r_sync2[CHANNELS:0]};
        end
    end

    logic [CHANNELS-1:0] w_cmp_in;
    logic [CHANNELS-1:0] w_cmp_rise;
    logic                w_sclk_rise;
    logic                w_sclk_fall;
    logic                w_mosi;
    logic                w_cs;
    logic                w_cs_fall;
    logic                w_cs_rise;

    assign w_cmp_in    = r_sync2[CHANNELS-1:0];
    assign w_cmp_rise  = r_sync2[CHANNELS-1:0] & ~r_sync3[CHANNELS-1:0];
    assign w_sclk_rise =  r_sync2[CHANNELS] & ~r_sync3[CHANNELS];
    assign w_sclk_fall = ~r_sync2[CHANNELS] &  r_sync3[CHANNELS];
    assign w_mosi      = r_sync2[CHANNELS+1];
    assign w_cs        = r_sync2[CHANNELS+2];
    assign w_cs_fall   = ~w_cs &  r_sync3[CHANNELS+1];
    assign w_cs_rise   =  w_cs & ~r_sync3[CHANNELS+1];

    // ------------------------------------------------------------------
    // Per-channel capture engines
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]    w_period_lat [CHANNELS];
    logic [WIDTH-1:0]    w_high_lat   [CHANNELS];
    logic [CHANNELS-1:0] w_ready;
    logic [CHANNELS-1:0] w_ovf;
    logic [CHANNELS-1:0] w_clear;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic             r_armed;
            logic             r_ready;
            logic             r_ovf;
            logic [WIDTH-1:0] r_period_cnt;
            logic [WIDTH-1:0] r_high_cnt;
            logic [WIDTH-1:0] r_period_lat;
            logic [WIDTH-1:0] r_high_lat;
            logic             w_event;
            logic             w_in;
            logic             w_sat;

            assign w_in    = w_cmp_in[gi];
            assign w_event = w_cmp_rise[gi];
            // Flag only the step into saturation so a parked counter does
            // not re-raise ovf right after a host clear.
            assign w_sat   = !w_event &&
                             ((r_period_cnt == c_MAX_M1) ||
                              (w_in && (r_high_cnt == c_MAX_M1)));

            // Interval counters, latches and sticky flags
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_armed      <= 1'b0;
                    r_ready      <= 1'b0;
                    r_ovf        <= 1'b0;
                    r_period_cnt <= '0;
                    r_high_cnt   <= '0;
                    r_period_lat <= '0;
                    r_high_lat   <= '0;
                end else begin
                    if (w_event) begin
                        // The event cycle itself belongs to the new interval.
                        r_period_cnt <= c_CNT_ONE;
                        r_high_cnt   <= c_CNT_ONE;
                        r_armed      <= 1'b1;
                        if (r_armed) begin
                            r_period_lat <= r_period_cnt;
                            r_high_lat   <= r_high_cnt;
                        end
                    end else begin
                        if (r_period_cnt != c_MAX) begin
                            r_period_cnt <= r_period_cnt + 1'b1;
                        end
                        if (w_in && (r_high_cnt != c_MAX)) begin
                            r_high_cnt <= r_high_cnt + 1'b1;
                        end
                    end

                    // A fresh capture outranks a host clear in the same cycle.
                    if (w_event && r_armed) begin
                        r_ready <= 1'b1;
                    end else if (w_clear[gi]) begin
                        r_ready <= 1'b0;
                    end

                    if (w_sat) begin
                        r_ovf <= 1'b1;
                    end else if (w_clear[gi]) begin
                        r_ovf <= 1'b0;
                    end
                end
            end

            assign w_period_lat[gi] = r_period_lat;
            assign w_high_lat[gi]   = r_high_lat;
            assign w_ready[gi]      = r_ready;
            assign w_ovf[gi]        = r_ovf;
        end
    endgenerate

    assign ready = w_ready;

    // ------------------------------------------------------------------
    // SPI slave
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } spi_state_t;

    spi_state_t          r_state;
    spi_state_t          w_state_nxt;
    logic                w_complete;
    logic [6:0]          r_bitcnt;
    logic [6:0]          r_cmd;
    logic [c_RESP_W-1:0] r_shift;
    logic [CHW-1:0]      r_sel_ch;
    logic                r_sel_valid;
    logic                r_miso;

    logic [7:0]          w_cmd_full;
    logic [CHW-1:0]      w_cmd_ch;
    logic                w_cmd_valid;
    logic [WIDTH-1:0]    w_sel_lat;
    logic                w_sel_ready;
    logic                w_sel_ovf;
    logic [c_LATW-1:0]   w_lat_ext;
    logic [c_RESP_W-1:0] w_snapshot;

    // Full command byte as it stands on the 8th rising edge
    assign w_cmd_full  = {r_cmd, w_mosi};
    assign w_cmd_ch    = w_cmd_full[CHW-1:0];
    assign w_cmd_valid = ({1'b0, w_cmd_ch} < c_NCH);

    // Response image: status byte followed by the zero-extended latch
    always_comb begin
        w_sel_lat   = '0;
        w_sel_ready = 1'b0;
        w_sel_ovf   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_cmd_valid && (w_cmd_ch == CHW'(i))) begin
                w_sel_lat   = w_cmd_full[7] ? w_period_lat[i] : w_high_lat[i];
                w_sel_ready = w_ready[i];
                w_sel_ovf   = w_ovf[i];
            end
        end
        w_lat_ext              = '0;
        w_lat_ext[WIDTH-1:0]   = w_sel_lat;
        w_snapshot             = {w_sel_ready, w_sel_ovf, 6'b0, w_lat_ext};
    end

    // Next-state logic; any cs rise ends the transaction
    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
        if (w_cs_rise) begin
            w_state_nxt = S_IDLE;
            w_complete  = (r_state == S_DONE);
        end else begin
            case (r_state)
                S_IDLE: if (w_cs_fall) w_state_nxt = S_CMD;
                S_CMD:  if (w_sclk_rise && (r_bitcnt == 7'd7)) w_state_nxt = S_DATA;
                S_DATA: if (w_sclk_rise && (r_bitcnt == c_LAST_BIT)) w_state_nxt = S_DONE;
                S_DONE: w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_clear = (w_complete && r_sel_valid) ? (c_ONE_CH << r_sel_ch) : '0;

    // SPI state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bit counter, command capture, response shifter and MISO register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bitcnt    <= '0;
            r_cmd       <= '0;
            r_shift     <= '0;
            r_sel_ch    <= '0;
            r_sel_valid <= 1'b0;
            r_miso      <= 1'b0;
        end else begin
            if (w_cs_fall) begin
                r_bitcnt <= '0;
            end else if (w_sclk_rise && ((r_state == S_CMD) || (r_state == S_DATA))) begin
                r_bitcnt <= r_bitcnt + 1'b1;
            end

            if (w_cs_rise) begin
                r_shift     <= '0;
                r_sel_valid <= 1'b0;
            end else if ((r_state == S_CMD) && w_sclk_rise) begin
                r_cmd <= w_cmd_full[6:0];
                if (r_bitcnt == 7'd7) begin
                    r_shift     <= w_snapshot;
                    r_sel_ch    <= w_cmd_ch;
                    r_sel_valid <= w_cmd_valid;
                end
            end else if ((r_state == S_DATA) && w_sclk_fall) begin
                r_shift <= {r_shift[c_RESP_W-2:0], 1'b0};
            end

            if (w_cs || (r_state == S_IDLE)) begin
                r_miso <= 1'b0;
            end else if (w_sclk_fall) begin
                r_miso <= (r_state == S_DATA) ? r_shift[c_RESP_W-1] : 1'b0;
            end
        end
    end

    assign spi_miso = r_miso;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture_spi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pwm_capture_spi
// Description : Directed self-checking bench; instance A (4 ch, 24 bit) and
//               instance B (3 ch, 8 bit) share clock, reset and SPI clock/data.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pwm_capture_spi;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] comp_a;
    logic [2:0] comp_b;
    logic       sclk;
    logic       mosi;
    logic       cs_a;
    logic       cs_b;
    logic       miso_a;
    logic       miso_b;
    logic [3:0] ready_a;
    logic [2:0] ready_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int last_rise;
    int race_cyc;

    always #42 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_capture_spi #(.CHANNELS(4), .WIDTH(24)) u_dut_a (
        .clk(clk), .rst(rst), .comparator(comp_a), .spi_clk(sclk),
        .spi_mosi(mosi), .spi_cs(cs_a), .spi_miso(miso_a), .ready(ready_a)
    );

    pwm_capture_spi #(.CHANNELS(3), .WIDTH(8)) u_dut_b (
        .clk(clk), .rst(rst), .comparator(comp_b), .spi_clk(sclk),
        .spi_mosi(mosi), .spi_cs(cs_b), .spi_miso(miso_b), .ready(ready_b)
    );

    // One comparator pulse: rise now, high for hi cycles, low for lo cycles
    task automatic pulse(input bit on_b, input int ch, input int hi, input int lo);
        if (on_b) comp_b[ch] = 1'b1; else comp_a[ch] = 1'b1;
        last_rise = cyc;
        repeat (hi) @(negedge clk);
        if (on_b) comp_b[ch] = 1'b0; else comp_a[ch] = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // SPI mode-0 host, half period 4 clk; race_a rises comparators with cs
    task automatic spi_xfer(input bit on_b, input logic [7:0] cmd, input int nbits,
                            input bit raise_cs, input logic [3:0] race_a,
                            output logic [63:0] rx);
        rx = '0;
        if (on_b) cs_b = 1'b0; else cs_a = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 8) ? cmd[7-i] : 1'b0;
            repeat (4) @(negedge clk);
            rx   = {rx[62:0], (on_b ? miso_b : miso_a)};
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        if (raise_cs) begin
            repeat (4) @(negedge clk);
            if (on_b) cs_b = 1'b1; else cs_a = 1'b1;
            comp_a   = comp_a | race_a;
            race_cyc = cyc;
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; comp_a = '0; comp_b = '0; sclk = 1'b0; mosi = 1'b0;
        cs_a = 1'b1; cs_b = 1'b1;
        repeat (12) @(negedge clk);
        n_checks++;
        if (miso_a !== 1'b0 || miso_b !== 1'b0) begin
            n_errors++; $display("FAIL reset_miso: got %b/%b expected 0/0", miso_a, miso_b);
        end
        n_checks++;
        if (ready_a !== 4'b0 || ready_b !== 3'b0) begin
            n_errors++; $display("FAIL reset_ready: got %b/%b expected 0", ready_a, ready_b);
        end
        repeat (12) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_capture();
        pulse(1'b0, 0, 30, 70);
        n_checks++;
        if (ready_a !== 4'b0000) begin
            n_errors++; $display("FAIL arm_only: got %b expected 0000", ready_a);
        end
        pulse(1'b0, 0, 30, 70);
        n_checks++;
        if (ready_a !== 4'b0001) begin
            n_errors++; $display("FAIL ready_after_2nd: got %b expected 0001", ready_a);
        end
        pulse(1'b0, 0, 30, 70);
    endtask

    task automatic test_read();
        logic [63:0] rx;
        spi_xfer(1'b0, 8'h80, 40, 1'b1, 4'b0, rx);
        n_checks++;
        if (rx[39:32] !== 8'h00) begin
            n_errors++; $display("FAIL cmd_phase_miso: got %h expected 00", rx[39:32]);
        end
        n_checks++;
        if (rx[31:24] !== 8'h80 || rx[23:0] !== 24'h000064) begin
            n_errors++; $display("FAIL period_read: got %h %h expected 80 000064", rx[31:24], rx[23:0]);
        end
        n_checks++;
        if (ready_a[0] !== 1'b0) begin
            n_errors++; $display("FAIL clear_after_read: got %b expected 0", ready_a[0]);
        end
        pulse(1'b0, 0, 30, 70);
        pulse(1'b0, 0, 30, 70);
        spi_xfer(1'b0, 8'h00, 40, 1'b1, 4'b0, rx);
        n_checks++;
        if (rx[31:24] !== 8'h80 || rx[23:0] !== 24'h00001E) begin
            n_errors++; $display("FAIL high_read: got %h %h expected 80 00001e", rx[31:24], rx[23:0]);
        end
    endtask

    task automatic test_ovf_width8();
        logic [63:0] rx;
        pulse(1'b1, 1, 30, 270);
        pulse(1'b1, 1, 30, 270);
        repeat (400) @(negedge clk);
        spi_xfer(1'b1, 8'h83, 24, 1'b1, 4'b0, rx);
        n_checks++;
        if (rx[23:0] !== 24'h0) begin
            n_errors++; $display("FAIL invalid_ch_b: got %h expected 000000", rx[23:0]);
        end
        n_checks++;
        if (ready_b !== 3'b010) begin
            n_errors++; $display("FAIL invalid_no_clear_b: got %b expected 010", ready_b);
        end
        spi_xfer(1'b1, 8'h81, 24, 1'b1, 4'b0, rx);
        n_checks++;
        if (rx[15:8] !== 8'hC0 || rx[7:0] !== 8'hFF) begin
            n_errors++; $display("FAIL sat_read: got %h %h expected c0 ff", rx[15:8], rx[7:0]);
        end
        spi_xfer(1'b1, 8'h80, 24, 1'b1, 4'b0, rx);
        n_checks++;
        if (rx[15:8] !== 8'h40 || rx[7:0] !== 8'h00) begin
            n_errors++; $display("FAIL idle_ovf: got %h %h expected 40 00", rx[15:8], rx[7:0]);
        end
        spi_xfer(1'b1, 8'h81, 24, 1'b1, 4'b0, rx);
        n_checks++;
        if (rx[15:8] !== 8'h00 || rx[7:0] !== 8'hFF) begin
            n_errors++; $display("FAIL flags_cleared: got %h %h expected 00 ff", rx[15:8], rx[7:0]);
        end
    endtask

    task automatic test_abort();
        logic [63:0] rx;
        pulse(1'b0, 1, 10, 40);
        pulse(1'b0, 1, 10, 40);
        spi_xfer(1'b0, 8'h81, 16, 1'b1, 4'b0, rx);
        n_checks++;
        if (ready_a[1] !== 1'b1) begin
            n_errors++; $display("FAIL abort_keeps_ready: got %b expected 1", ready_a[1]);
        end
        spi_xfer(1'b0, 8'h81, 40, 1'b1, 4'b0, rx);
        n_checks++;
        if (rx[31:24] !== 8'h80 || rx[23:0] !== 24'd50) begin
            n_errors++; $display("FAIL read_after_abort: got %h %h expected 80 000032", rx[31:24], rx[23:0]);
        end
        n_checks++;
        if (ready_a[1] !== 1'b0) begin
            n_errors++; $display("FAIL clear_after_abort_read: got %b expected 0", ready_a[1]);
        end
    endtask

    task automatic test_clear_race();
        logic [63:0] rx;
        int          c1;
        int          exp_period;
        pulse(1'b0, 2, 10, 30);
        pulse(1'b0, 2, 10, 30);
        c1 = last_rise;
        spi_xfer(1'b0, 8'h82, 40, 1'b1, 4'b0100, rx);
        comp_a[2] = 1'b0;
        exp_period = race_cyc - c1;
        n_checks++;
        if (rx[31:24] !== 8'h80 || rx[23:0] !== 24'd40) begin
            n_errors++; $display("FAIL race_snapshot: got %h %h expected 80 000028", rx[31:24], rx[23:0]);
        end
        n_checks++;
        if (ready_a[2] !== 1'b1) begin
            n_errors++; $display("FAIL event_beats_clear: got %b expected 1", ready_a[2]);
        end
        spi_xfer(1'b0, 8'h87, 40, 1'b1, 4'b0, rx);
        n_checks++;
        if (rx[39:0] !== 40'h0) begin
            n_errors++; $display("FAIL idle_ch3_read: got %h expected 0", rx[39:0]);
        end
        n_checks++;
        if (ready_a !== 4'b0100) begin
            n_errors++; $display("FAIL ch3_read_no_clear: got %b expected 0100", ready_a);
        end
        spi_xfer(1'b0, 8'h82, 40, 1'b1, 4'b0, rx);
        n_checks++;
        if (rx[31:24] !== 8'h80 || rx[23:0] !== 24'(exp_period)) begin
            n_errors++; $display("FAIL race_value: got %h %h expected 80 %h", rx[31:24], rx[23:0], 24'(exp_period));
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rx;
        pulse(1'b0, 0, 20, 20);
        comp_a[0] = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (ready_a[0] !== 1'b1) begin
            n_errors++; $display("FAIL pre_reset_ready: got %b expected 1", ready_a[0]);
        end
        spi_xfer(1'b0, 8'h80, 20, 1'b0, 4'b0, rx);
        rst = 1'b0;
        #1;
        n_checks++;
        if (miso_a !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset_miso: got %b expected 0", miso_a);
        end
        n_checks++;
        if (ready_a !== 4'b0 || ready_b !== 3'b0) begin
            n_errors++; $display("FAIL mid_reset_ready: got %b/%b expected 0", ready_a, ready_b);
        end
        @(negedge clk);
        cs_a = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (ready_a !== 4'b0) begin
            n_errors++; $display("FAIL post_reset_arm: got %b expected 0000", ready_a);
        end
        comp_a[0] = 1'b0;
        repeat (10) @(negedge clk);
        pulse(1'b0, 0, 10, 10);
        n_checks++;
        if (ready_a !== 4'b0001) begin
            n_errors++; $display("FAIL post_reset_capture: got %b expected 0001", ready_a);
        end
    endtask

    // Run-time bound
    initial begin
        #8ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_capture();
        test_read();
        test_ovf_width8();
        test_abort();
        test_clear_race();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
